// File: rtl/bus_arbiter.sv
// Round-robin N:1 memory-bus arbiter with lock-until-accepted and in-order response routing; optional sticky err_o under BUS_ARBITER_ERR_EN.
// Latency: 0-cycle grant (request path) and 0-cycle response path (rvalid/rdata), with registered state only.
// Backpressure: mem_ready_i low holds the grant locked; a full ID FIFO drops mem_valid_o until the registered count falls.

module sync_fifo #(
  parameter int Width = 1,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_vld,
  input  logic [Width-1:0] push_dat,
  input  logic             pop_vld,
  output logic [Width-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_vld) wr_ptr_q <= wrap_inc(wr_ptr_q);
      if (pop_vld)  rd_ptr_q <= wrap_inc(rd_ptr_q);
      if (push_vld && !pop_vld)      count_q <= count_q + CntW'(1);
      else if (!push_vld && pop_vld) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_vld) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
endmodule

module bus_arbiter #(
  parameter int NumReq         = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
`ifdef BUS_ARBITER_ERR_EN
  output logic                          err_o,
`endif
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
  input  logic [NumReq*DataWidth/8-1:0] req_wmask_i,
  output logic [DataWidth-1:0]          req_rdata_o,
  output logic [NumReq-1:0]             req_rvalid_o,
  output logic                          mem_valid_o,
  input  logic                          mem_ready_i,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic [DataWidth-1:0]          mem_wdata_o,
  output logic [DataWidth/8-1:0]        mem_wmask_o,
  input  logic [DataWidth-1:0]          mem_rdata_i,
  input  logic                          mem_rvalid_i
);
  localparam int IdxW  = $clog2(NumReq);
  localparam int MaskW = DataWidth / 8;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [MaskW-1:0]     wmask;
  } req_t;

  logic [0:0]      state_q;
  logic [IdxW-1:0] ptr_q, lock_idx_q;
  logic [IdxW-1:0] scan_idx, grant_idx, sel_idx, head_idx;
  logic            scan_found, grant_vld, accept, pop_vld;
  logic            fifo_full, fifo_empty;
  int              scan_pos;
  req_t            mem_req;

  always_comb begin
    scan_found = 1'b0;
    scan_idx   = ptr_q;
    scan_pos   = 0;
    for (int k = 0; k < NumReq; k++) begin
      scan_pos = int'(ptr_q) + k;
      if (scan_pos >= NumReq) scan_pos = scan_pos - NumReq;
      if (!scan_found && req_valid_i[scan_pos]) begin
        scan_found = 1'b1;
        scan_idx   = IdxW'(scan_pos);
      end
    end
  end

  assign grant_idx   = (state_q == LOCKED) ? lock_idx_q : scan_idx;
  assign grant_vld   = (state_q == LOCKED) || scan_found;
  // Full is judged on the registered count; a same-cycle pop does not free a slot.
  assign mem_valid_o = rst_ni && grant_vld && !fifo_full;
  assign accept      = mem_valid_o && mem_ready_i;
  assign sel_idx     = rst_ni ? grant_idx : '0;

  always_comb begin
    mem_req = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (sel_idx == IdxW'(k)) begin
        mem_req.addr  = req_addr_i[k*AddrWidth +: AddrWidth];
        mem_req.wdata = req_wdata_i[k*DataWidth +: DataWidth];
        mem_req.wmask = req_wmask_i[k*MaskW +: MaskW];
      end
    end
  end

  assign mem_addr_o  = mem_req.addr;
  assign mem_wdata_o = mem_req.wdata;
  assign mem_wmask_o = mem_req.wmask;

  // Responses with nothing outstanding are dropped rather than popped.
  assign pop_vld     = rst_ni && mem_rvalid_i && !fifo_empty;
  assign req_rdata_o = mem_rdata_i;

  always_comb begin
    req_ready_o  = '0;
    req_rvalid_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      req_ready_o[k]  = accept && (grant_idx == IdxW'(k));
      req_rvalid_o[k] = pop_vld && (head_idx == IdxW'(k));
    end
  end

  sync_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_vld (accept),
    .push_dat (grant_idx),
    .pop_vld  (pop_vld),
    .head_dat (head_idx),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else begin
      if (accept) ptr_q <= (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + IdxW'(1);
      case (state_q)
        IDLE: begin
          if (mem_valid_o && !mem_ready_i) begin
            state_q    <= LOCKED;
            lock_idx_q <= grant_idx;
          end
        end
        default: begin
          if (accept) state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef BUS_ARBITER_ERR_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                         err_o <= 1'b0;
    else if (mem_rvalid_i && fifo_empty) err_o <= 1'b1;
  end
`endif
endmodule
